irq_encoder_8x3: RTL and testbench

IRQ_ENCODER_8X3 -- requirements
Module: irq_encoder_8x3

---
 rtl/irq_encoder_8x3_if.sv | 27 ++
 rtl/irq_encoder_8x3.sv | 88 ++++++++
 tb/tb_irq_encoder_8x3.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/irq_encoder_8x3_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : irq_encoder_8x3_if
// Purpose  : Request/grant bundle between an interrupt source and the encoder.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
interface irq_encoder_8x3_if;
  logic [7:0] req;
  logic [7:0] mask;
  logic       ack;
  logic       clr_ovr;
  logic [2:0] code;
  logic       valid;
  logic [7:0] pending;
  logic [7:0] overrun;

  modport master (
    output req, mask, ack, clr_ovr,
    input  code, valid, pending, overrun
  );

  modport slave (
    input  req, mask, ack, clr_ovr,
    output code, valid, pending, overrun
  );
endinterface
`default_nettype wire

// File: rtl/irq_encoder_8x3.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : irq_encoder_8x3
// Purpose  : 8-to-3 interrupt encoder, fixed or rotating priority, with
//            latched pending bits, sticky overrun flags and ack handshake.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
module irq_encoder_8x3 #(
  parameter int ROUND_ROBIN = 0
) (
  input  logic              clk,
  input  logic              reset,
  irq_encoder_8x3_if.slave  bus
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  logic [0:0] r_state;
  logic [2:0] r_code;
  logic [2:0] r_last;
  logic [7:0] r_pending;
  logic [7:0] r_overrun;

  logic       w_accept;
  logic [7:0] w_clear;
  logic [7:0] w_ovr_set;
  logic [7:0] w_cand;
  logic [2:0] w_start;
  logic [2:0] w_idx;
  logic [2:0] w_sel;
  logic       w_found;

  assign w_accept  = (r_state == S_GRANT) && bus.ack;
  // A request arriving on the acked bit keeps it pending.
  assign w_clear   = w_accept ? ((8'b1 << r_code) & ~bus.req) : 8'h00;
  assign w_ovr_set = bus.req & r_pending & ~w_clear;
  assign w_cand    = (r_pending | bus.req) & ~bus.mask;
  assign w_start   = (ROUND_ROBIN != 0) ? (r_last + 3'd1) : 3'd0;

  always_comb begin
    w_sel   = 3'd0;
    w_found = 1'b0;
    w_idx   = 3'd0;
    for (int k = 0; k < 8; k++) begin
      w_idx = w_start + 3'(k);
      if (!w_found && w_cand[w_idx]) begin
        w_sel   = w_idx;
        w_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_code    <= 3'd0;
      r_last    <= 3'd7;
      r_pending <= 8'h00;
      r_overrun <= 8'h00;
    end else begin
      r_pending <= (r_pending | bus.req) & ~w_clear;
      r_overrun <= w_ovr_set | (r_overrun & ~{8{bus.clr_ovr}});
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_code  <= w_sel;
            r_state <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (bus.ack) begin
            r_last  <= r_code;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.code    = r_code;
  assign bus.valid   = (r_state == S_GRANT);
  assign bus.pending = r_pending;
  assign bus.overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_irq_encoder_8x3.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_irq_encoder_8x3
// Purpose  : Directed scoreboard bench for fixed and rotating priority builds.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_irq_encoder_8x3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cycle = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  irq_encoder_8x3_if bus0 ();
  irq_encoder_8x3_if bus1 ();

  irq_encoder_8x3 #(.ROUND_ROBIN(0)) dut0 (.clk(clk), .reset(rst), .bus(bus0));
  irq_encoder_8x3 #(.ROUND_ROBIN(1)) dut1 (.clk(clk), .reset(rst), .bus(bus1));

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  // -1 in an expected field means "not checked on this cycle".
  typedef struct {
    int    due;
    int    d;
    string nm;
    int    ev;
    int    ec;
    int    ep;
    int    eo;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string nm, input logic [7:0] act, input int exp);
    n_checks++;
    if (act !== 8'(exp)) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", nm, act, 8'(exp));
    end
  endtask

  task automatic step(input int d, input logic [7:0] rq, mk, input logic ak, co, rs,
                      input string nm, input int ev, ec, ep, eo);
    exp_t e;
    @(negedge clk);
    rst           = rs;
    bus0.req      = (d == 0) ? rq : 8'h00;
    bus0.mask     = (d == 0) ? mk : 8'h00;
    bus0.ack      = (d == 0) ? ak : 1'b0;
    bus0.clr_ovr  = (d == 0) ? co : 1'b0;
    bus1.req      = (d == 1) ? rq : 8'h00;
    bus1.mask     = (d == 1) ? mk : 8'h00;
    bus1.ack      = (d == 1) ? ak : 1'b0;
    bus1.clr_ovr  = (d == 1) ? co : 1'b0;
    e.due = cycle + 1;
    e.d   = d;
    e.nm  = nm;
    e.ev  = ev;
    e.ec  = ec;
    e.ep  = ep;
    e.eo  = eo;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t       e;
    logic [7:0] av, ac, ap, ao;
    while (q.size() > 0 && q[0].due <= cycle) begin
      e  = q.pop_front();
      av = (e.d == 0) ? {7'd0, bus0.valid} : {7'd0, bus1.valid};
      ac = (e.d == 0) ? {5'd0, bus0.code}  : {5'd0, bus1.code};
      ap = (e.d == 0) ? bus0.pending : bus1.pending;
      ao = (e.d == 0) ? bus0.overrun : bus1.overrun;
      if (e.due < cycle) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s: sampled late at cycle %0d, due %0d", e.nm, cycle, e.due);
      end
      if (e.ev >= 0) chk({e.nm, " valid"},   av, e.ev);
      if (e.ec >= 0) chk({e.nm, " code"},    ac, e.ec);
      if (e.ep >= 0) chk({e.nm, " pending"}, ap, e.ep);
      if (e.eo >= 0) chk({e.nm, " overrun"}, ao, e.eo);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus0.req = 8'h00; bus0.mask = 8'h00; bus0.ack = 1'b0; bus0.clr_ovr = 1'b0;
    bus1.req = 8'h00; bus1.mask = 8'h00; bus1.ack = 1'b0; bus1.clr_ovr = 1'b0;

    //   d  req    mask   ack co  rst  name            v   code pend   ovr
    step(0, 8'h00, 8'h00, 0,  0,  1,  "reset",         0,  0,  'h00, 'h00);
    // Fixed priority: lowest bit first
    step(0, 8'h24, 8'h00, 0,  0,  0,  "fp_grant2",     1,  2,  'h24, 'h00);
    step(0, 8'h00, 8'h00, 1,  0,  0,  "fp_ack2",       0, -1,  'h20, 'h00);
    step(0, 8'h00, 8'h00, 0,  0,  0,  "fp_grant5",     1,  5,  'h20, -1);
    step(0, 8'h00, 8'h00, 1,  0,  0,  "fp_ack5",       0, -1,  'h00, 'h00);
    // Grant holds against higher priority and mask changes
    step(0, 8'h20, 8'h00, 0,  0,  0,  "hold_grant5",   1,  5,  'h20, -1);
    step(0, 8'h01, 8'h00, 0,  0,  0,  "hold_req0",     1,  5,  'h21, -1);
    step(0, 8'h00, 8'hFF, 0,  0,  0,  "hold_masked",   1,  5,  'h21, -1);
    step(0, 8'h00, 8'h00, 1,  0,  0,  "hold_ack5",     0, -1,  'h01, -1);
    step(0, 8'h00, 8'h00, 0,  0,  0,  "hold_grant0",   1,  0,  'h01, -1);
    step(0, 8'h00, 8'h00, 1,  0,  0,  "hold_ack0",     0, -1,  'h00, 'h00);
    // Masked request still latches
    step(0, 8'h01, 8'h01, 0,  0,  0,  "mask_latch",    0, -1,  'h01, -1);
    step(0, 8'h00, 8'h01, 0,  0,  0,  "mask_hold",     0, -1,  'h01, -1);
    step(0, 8'h00, 8'h00, 0,  0,  0,  "mask_release",  1,  0,  'h01, -1);
    step(0, 8'h00, 8'h00, 1,  0,  0,  "mask_ack",      0, -1,  'h00, 'h00);
    // Overrun set, clear, and set beating clear
    step(0, 8'h08, 8'h00, 0,  0,  0,  "ovr_first",     1,  3,  'h08, 'h00);
    step(0, 8'h00, 8'h00, 0,  0,  0,  "ovr_gap",       1,  3,  'h08, 'h00);
    step(0, 8'h08, 8'h00, 0,  0,  0,  "ovr_second",    1,  3,  'h08, 'h08);
    step(0, 8'h00, 8'h00, 0,  1,  0,  "ovr_clear",     1,  3,  'h08, 'h00);
    step(0, 8'h08, 8'h00, 0,  1,  0,  "ovr_set_wins",  1,  3,  'h08, 'h08);
    step(0, 8'h00, 8'h00, 1,  0,  0,  "ovr_ack",       0, -1,  'h00, 'h08);
    // Request on the acked bit keeps it pending
    step(0, 8'h10, 8'h00, 0,  0,  0,  "same_grant4",   1,  4,  'h10, 'h08);
    step(0, 8'h10, 8'h00, 1,  0,  0,  "same_ack_req",  0, -1,  'h10, 'h18);
    step(0, 8'h00, 8'h00, 0,  0,  0,  "same_regrant",  1,  4,  'h10, 'h18);
    step(0, 8'h00, 8'h00, 1,  0,  0,  "same_ack",      0, -1,  'h00, 'h18);
    // Ack while idle is ignored
    step(0, 8'h02, 8'h02, 0,  0,  0,  "idle_latch",    0, -1,  'h02, 'h18);
    step(0, 8'h00, 8'h02, 1,  0,  0,  "idle_ack",      0, -1,  'h02, 'h18);
    step(0, 8'h00, 8'h00, 0,  0,  0,  "idle_grant1",   1,  1,  'h02, 'h18);
    // Reset mid-grant wins over req and ack
    step(0, 8'hFF, 8'h00, 0,  0,  0,  "rst_fill",      1,  1,  'hFF, 'h1A);
    step(0, 8'hFF, 8'h00, 1,  1,  1,  "rst_midgrant",  0,  0,  'h00, 'h00);
    step(0, 8'h00, 8'h00, 1,  0,  0,  "rst_ack_after", 0,  0,  'h00, 'h00);
    // Rotating priority, starting at bit 0 after reset
    step(1, 8'h81, 8'h00, 0,  0,  0,  "rr_grant0",     1,  0,  'h81, 'h00);
    step(1, 8'h81, 8'h00, 1,  0,  0,  "rr_ack0",       0, -1,  'h81, 'h81);
    step(1, 8'h81, 8'h00, 0,  0,  0,  "rr_grant7",     1,  7,  'h81, -1);
    step(1, 8'h81, 8'h00, 1,  0,  0,  "rr_ack7",       0, -1,  'h81, -1);
    step(1, 8'h81, 8'h00, 0,  0,  0,  "rr_grant0b",    1,  0,  'h81, -1);
    step(1, 8'h81, 8'h00, 1,  0,  0,  "rr_ack0b",      0, -1,  'h81, -1);
    step(1, 8'h81, 8'h00, 0,  0,  0,  "rr_grant7b",    1,  7,  'h81, -1);
    step(1, 8'h00, 8'h00, 1,  0,  0,  "rr_ack7b",      0, -1,  'h01, -1);
    step(1, 8'h00, 8'h00, 0,  0,  0,  "rr_wrap0",      1,  0,  'h01, -1);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    if (q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
